// File: rtl/tinygpu_mem_pkg.sv
// Shared types and helpers for the data-memory path of the multi-SM system.
//   dmem_req_t     : one memory request (we, addr, wdata) at the default widths
//   arb_state_e    : lock state of the data-memory arbiter
//   onehot_to_idx  : index of the lowest set bit of a one-hot vector (0 if none)
package tinygpu_mem_pkg;

   localparam int DMEM_ADDR_W = 8;
   localparam int DMEM_DATA_W = 32;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } dmem_req_t;

   typedef enum logic {
      ARB_UNLOCKED = 1'b0,
      ARB_LOCKED   = 1'b1
   } arb_state_e;

   function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (oh[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter.
//   req   in  N       request vector
//   ptr   in  log2(N) index that currently has highest priority
//   mask  in  N       eligible requesters (0 = never granted)
//   grant out N       one-hot grant, or zero when nothing eligible requests
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   input  logic [N-1:0]     mask,
   output logic [N-1:0]     grant
);

   always_comb begin
      int   idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx] && mask[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port data memory among
// N_SM cores, with a fixed 1-cycle response channel back to each core.
// Optional feature: define DMEM_ARB_LOCK_EN to add req_lock and the lock FSM
// used for atomic read-modify-write sequences.
//
// Lock FSM (DMEM_ARB_LOCK_EN only)
//   state         | meaning
//   ARB_UNLOCKED  | plain round-robin among all requesters
//   ARB_LOCKED    | only owner_q may be granted until it issues an unlocked access
//
// Ports
//   clk, reset             clock / async active-high reset
//   req_valid/we/addr/wdata  per-core request (packed, core i at slice i)
//   req_lock               per-core lock request (DMEM_ARB_LOCK_EN only)
//   req_ready              one-hot grant this cycle
//   rsp_valid, rsp_rdata   one-hot response and shared read data, 1 cycle after accept
//   mem_en/we/addr/wdata   memory command, mem_rdata memory read data
module dmem_arbiter
   import tinygpu_mem_pkg::*;
#(
   parameter int N_SM   = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_SM-1:0]          req_valid,
   input  logic [N_SM-1:0]          req_we,
   input  logic [N_SM*ADDR_W-1:0]   req_addr,
   input  logic [N_SM*DATA_W-1:0]   req_wdata,
`ifdef DMEM_ARB_LOCK_EN
   input  logic [N_SM-1:0]          req_lock,
`endif
   output logic [N_SM-1:0]          req_ready,
   output logic [N_SM-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata
);

   localparam int PTR_W = $clog2(N_SM);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             rsp_vld_q, rsp_vld_d;
   logic [PTR_W-1:0] rsp_idx_q, rsp_idx_d;
   logic             rsp_we_q, rsp_we_d;

   logic [N_SM-1:0]  req_eff;
   logic [N_SM-1:0]  mask;
   logic [N_SM-1:0]  grant;
   logic             accept;
   logic [PTR_W-1:0] gnt_idx;

   // Nothing may be granted while reset is held, so all command outputs stay 0.
   assign req_eff = reset ? '0 : req_valid;

   rr_arbiter #(.N(N_SM), .PTR_W(PTR_W)) u_rr_arbiter (
      .req   (req_eff),
      .ptr   (ptr_q),
      .mask  (mask),
      .grant (grant)
   );

   assign req_ready = grant;
   assign accept    = |grant;
   assign gnt_idx   = PTR_W'(onehot_to_idx(32'(grant)));

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (accept) begin
         mem_en    = 1'b1;
         mem_we    = req_we[gnt_idx];
         mem_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
         mem_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (int'(gnt_idx) == N_SM-1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Response stage reloads every cycle so back-to-back accepts need no bubble.
   always_comb begin
      rsp_vld_d = accept;
      rsp_idx_d = gnt_idx;
      rsp_we_d  = mem_we;
   end

   assign rsp_valid = rsp_vld_q ? (N_SM'(1) << rsp_idx_q) : '0;
   assign rsp_rdata = (rsp_vld_q && !rsp_we_q) ? mem_rdata : '0;

`ifdef DMEM_ARB_LOCK_EN
   arb_state_e       state_q, state_d;
   logic [PTR_W-1:0] owner_q, owner_d;

   always_comb begin
      mask = '1;
      if (state_q == ARB_LOCKED) begin
         mask          = '0;
         mask[owner_q] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      if (accept) begin
         case (state_q)
            ARB_UNLOCKED: begin
               if (req_lock[gnt_idx]) begin
                  state_d = ARB_LOCKED;
                  owner_d = gnt_idx;
               end
            end
            ARB_LOCKED: begin
               // The mask guarantees any accept here is from the owner.
               if (!req_lock[gnt_idx]) state_d = ARB_UNLOCKED;
            end
            default: state_d = ARB_UNLOCKED;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ARB_UNLOCKED;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end
`else
   assign mask = '1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q     <= '0;
         rsp_vld_q <= 1'b0;
         rsp_idx_q <= '0;
         rsp_we_q  <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_idx_q <= rsp_idx_d;
         rsp_we_q  <= rsp_we_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (N_SM=4, ADDR_W=8, DATA_W=32) with a
// behavioural synchronous memory attached to the memory port.
module tb_dmem_arbiter;

   logic         clk;
   logic         reset;
   logic [3:0]   req_valid;
   logic [3:0]   req_we;
   logic [31:0]  req_addr;
   logic [127:0] req_wdata;
`ifdef DMEM_ARB_LOCK_EN
   logic [3:0]   req_lock;
`endif
   logic [3:0]   req_ready;
   logic [3:0]   rsp_valid;
   logic [31:0]  rsp_rdata;
   logic         mem_en;
   logic         mem_we;
   logic [7:0]   mem_addr;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;

   logic [31:0]  mem [256];

   int n_checks = 0;
   int n_pass   = 0;

   dmem_arbiter #(.N_SM(4), .ADDR_W(8), .DATA_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
`ifdef DMEM_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic we,
                          input logic [7:0] addr, input logic [31:0] wdata);
      req_valid[i]           = v;
      req_we[i]              = we;
      req_addr[i*8 +: 8]     = addr;
      req_wdata[i*32 +: 32]  = wdata;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
      req_lock  = '0;
`endif
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 32'h0;
      for (int a = 0; a < 4; a++) mem[a] = 32'h100 + a;
      mem_rdata = '0;
      clear_reqs();

      // Reset: combinational outputs forced to 0 even with requests present
      reset     = 1'b1;
      req_valid = 4'b1111;
      tick();
      #1;
      check("rst_ready", {28'h0, req_ready}, 32'h0);
      check("rst_mem_en", {31'h0, mem_en}, 32'h0);
      check("rst_rsp_valid", {28'h0, rsp_valid}, 32'h0);
      clear_reqs();
      tick();
      reset = 1'b0;

      // Test 1: core2 writes 0xDEADBEEF to 0x10, then reads it back
      tick();
      set_req(2, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
      #1;
      check("t1_wr_ready", {28'h0, req_ready}, 32'h4);
      check("t1_wr_mem_en", {31'h0, mem_en}, 32'h1);
      check("t1_wr_mem_we", {31'h0, mem_we}, 32'h1);
      check("t1_wr_addr", {24'h0, mem_addr}, 32'h10);
      check("t1_wr_wdata", mem_wdata, 32'hDEADBEEF);
      tick();
      check("t1_wr_rsp_valid", {28'h0, rsp_valid}, 32'h4);
      check("t1_wr_rsp_rdata", rsp_rdata, 32'h0);
      set_req(2, 1'b1, 1'b0, 8'h10, 32'h0);
      #1;
      check("t1_rd_ready", {28'h0, req_ready}, 32'h4);
      check("t1_rd_mem_we", {31'h0, mem_we}, 32'h0);
      tick();
      set_req(2, 1'b0, 1'b0, 8'h00, 32'h0);
      #1;
      check("t1_rd_rsp_valid", {28'h0, rsp_valid}, 32'h4);
      check("t1_rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("t1_idle_mem_en", {31'h0, mem_en}, 32'h0);

      // Test 2: all cores read continuously from reset
      reset = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 8'(i), 32'h0);
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         check("t2_ready", {28'h0, req_ready}, 32'h1 << (k % 4));
         check("t2_mem_en", {31'h0, mem_en}, 32'h1);
         check("t2_mem_addr", {24'h0, mem_addr}, k % 4);
         if (k > 0) begin
            check("t2_rsp_valid", {28'h0, rsp_valid}, 32'h1 << ((k - 1) % 4));
            check("t2_rsp_rdata", rsp_rdata, 32'h100 + ((k - 1) % 4));
         end
         tick();
      end
      clear_reqs();
      #1;
      check("t2_last_rsp_valid", {28'h0, rsp_valid}, 32'h8);
      check("t2_last_rsp_rdata", rsp_rdata, 32'h103);

      // Test 3: rr_ptr now 0. Core3 alone, then cores 0+1 (ptr wrapped to 0), then 1
      set_req(3, 1'b1, 1'b0, 8'h03, 32'h0);
      #1;
      check("t3_ready_c3", {28'h0, req_ready}, 32'h8);
      tick();
      clear_reqs();
      set_req(0, 1'b1, 1'b0, 8'h00, 32'h0);
      set_req(1, 1'b1, 1'b0, 8'h01, 32'h0);
      #1;
      check("t3_ready_wrap", {28'h0, req_ready}, 32'h1);
      tick();
      #1;
      check("t3_ready_next", {28'h0, req_ready}, 32'h2);
      tick();
      clear_reqs();
      tick();

      // Test 4: reset right after a read accept by core1 drops the response
      do_reset();
      set_req(1, 1'b1, 1'b0, 8'h01, 32'h0);
      #1;
      check("t4_ready_c1", {28'h0, req_ready}, 32'h2);
      @(posedge clk);
      #1;
      clear_reqs();
      reset = 1'b1;
      #1;
      check("t4_rsp_in_reset", {28'h0, rsp_valid}, 32'h0);
      tick();
      reset = 1'b0;
      #1;
      check("t4_rsp_after", {28'h0, rsp_valid}, 32'h0);
      set_req(0, 1'b1, 1'b0, 8'h00, 32'h0);
      set_req(3, 1'b1, 1'b0, 8'h03, 32'h0);
      #1;
      check("t4_ready_lowest", {28'h0, req_ready}, 32'h1);
      tick();
      clear_reqs();
      #1;
      check("t4_rsp_c0", {28'h0, rsp_valid}, 32'h1);

      // Test 6: idle 10 cycles, rr_ptr must stay at 1
      tick();
      for (int k = 0; k < 10; k++) begin
         #1;
         check("t6_ready", {28'h0, req_ready}, 32'h0);
         check("t6_mem_en", {31'h0, mem_en}, 32'h0);
         check("t6_rsp_valid", {28'h0, rsp_valid}, 32'h0);
         tick();
      end
      req_valid = 4'b1111;
      #1;
      check("t6_ptr_held", {28'h0, req_ready}, 32'h2);
      clear_reqs();

`ifdef DMEM_ARB_LOCK_EN
      // Test 5: locked RMW by core1 while cores 0 and 2 request
      do_reset();
      set_req(0, 1'b1, 1'b1, 8'h30, 32'h1);
      #1;
      check("t5_pre_c0", {28'h0, req_ready}, 32'h1);
      tick();
      set_req(0, 1'b1, 1'b0, 8'h00, 32'h0);
      set_req(1, 1'b1, 1'b0, 8'h20, 32'h0);
      set_req(2, 1'b1, 1'b0, 8'h02, 32'h0);
      req_lock[1] = 1'b1;
      #1;
      check("t5_lock_rd", {28'h0, req_ready}, 32'h2);
      tick();
      req_valid[1] = 1'b0;
      req_lock[1]  = 1'b0;
      #1;
      check("t5_locked_block", {28'h0, req_ready}, 32'h0);
      check("t5_locked_mem_en", {31'h0, mem_en}, 32'h0);
      tick();
      set_req(1, 1'b1, 1'b1, 8'h20, 32'h55);
      #1;
      check("t5_unlock_wr", {28'h0, req_ready}, 32'h2);
      tick();
      req_valid[1] = 1'b0;
      #1;
      check("t5_after_c2", {28'h0, req_ready}, 32'h4);
      clear_reqs();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
